// File: rtl/weights_load_ctrl_if.sv
// Weight stream interface between the weight load controller and the conv
// engine weight-load port.
//   w_valid  master -> slave   word valid
//   w_ready  slave  -> master  consumer accepts when w_valid & w_ready
//   w_data   master -> slave   weight word
//   w_ch     master -> slave   output channel of w_data
//   w_idx    master -> slave   in-kernel index of w_data
//   w_last   master -> slave   1 on the final index of a kernel
interface weights_load_ctrl_if #(
    parameter int PARA_WIDTH = 8,
    parameter int CH_WIDTH   = 2,
    parameter int ADDR_WIDTH = 5
);
    logic                  w_valid;
    logic                  w_ready;
    logic [PARA_WIDTH-1:0] w_data;
    logic [CH_WIDTH-1:0]   w_ch;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_last;

    modport master (output w_valid, w_data, w_ch, w_idx, w_last, input w_ready);
    modport slave  (input w_valid, w_data, w_ch, w_idx, w_last, output w_ready);
endinterface

// File: rtl/weights_load_ctrl.sv
// Weight load controller: reads every kernel weight out of NUM_CH combinational
// single-kernel ROMs (shared address bus, one-hot read enables), registers each
// word and streams it to the conv engine in channel-major order over a
// valid/ready interface, one word per cycle when not back-pressured.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       begin a full load (only looked at in IDLE)
//   busy        high in RUN and DONE
//   done        one-cycle pulse after the final word handshake
//   rom_r_en    one-hot ROM read enable (0 when no read is issued)
//   rom_raddr   shared ROM address (0 when no read is issued)
//   rom_dout    ROM data, channel c at [c*PARA_WIDTH +: PARA_WIDTH]
//   w_if        weight stream (master side)
module weights_load_ctrl #(
    parameter int PARA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 25,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_CH      = 4,
    parameter int CH_WIDTH    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_CH-1:0]            rom_r_en,
    output logic [ADDR_WIDTH-1:0]        rom_raddr,
    input  logic [NUM_CH*PARA_WIDTH-1:0] rom_dout,
    weights_load_ctrl_if.master          w_if
);
    localparam int TOTAL = NUM_CH * KERNEL_SIZE;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0]      TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [CH_WIDTH-1:0]   LAST_CH  = CH_WIDTH'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CH_WIDTH-1:0]   issue_ch_q, issue_ch_d;
    logic [ADDR_WIDTH-1:0] issue_idx_q, issue_idx_d;
    logic                  w_valid_q, w_valid_d;
    logic [PARA_WIDTH-1:0] w_data_q, w_data_d;
    logic [CH_WIDTH-1:0]   w_ch_q, w_ch_d;
    logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
    logic                  w_last_q, w_last_d;

    logic                  issue;
    logic                  handshake;
    logic                  last_hs;
    logic [PARA_WIDTH-1:0] rd_word;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        issue_ch_d  = issue_ch_q;
        issue_idx_d = issue_idx_q;
        w_valid_d   = w_valid_q;
        w_data_d    = w_data_q;
        w_ch_d      = w_ch_q;
        w_idx_d     = w_idx_q;
        w_last_d    = w_last_q;
        rom_r_en    = '0;
        rom_raddr   = '0;
        rd_word     = '0;

        handshake = w_valid_q & w_if.w_ready;
        last_hs   = handshake & (w_ch_q == LAST_CH) & (w_idx_q == LAST_IDX);
        // A new read may only overwrite the output register once it is empty
        // or being consumed this cycle; that is what keeps words stable under
        // backpressure and guarantees nothing is dropped.
        issue = (state_q == S_RUN) & (issue_cnt_q < TOTAL_C) & (~w_valid_q | w_if.w_ready);

        unique case (state_q)
            S_IDLE: begin
                // Counters are cleared here so every load starts at ch0/idx0.
                issue_cnt_d = '0;
                issue_ch_d  = '0;
                issue_idx_d = '0;
                if (start) state_d = S_RUN;
            end
            S_RUN:   if (last_hs) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (handshake) w_valid_d = 1'b0;

        if (issue) begin
            // Explicit compare per channel keeps the enable one-hot and never
            // selects a ROM slice outside the bank.
            for (int c = 0; c < NUM_CH; c++) begin
                if (issue_ch_q == CH_WIDTH'(c)) begin
                    rom_r_en[c] = 1'b1;
                    rd_word     = rom_dout[c*PARA_WIDTH +: PARA_WIDTH];
                end
            end
            rom_raddr   = issue_idx_q;
            w_valid_d   = 1'b1;
            w_data_d    = rd_word;
            w_ch_d      = issue_ch_q;
            w_idx_d     = issue_idx_q;
            w_last_d    = (issue_idx_q == LAST_IDX);
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_idx_q == LAST_IDX) begin
                issue_idx_d = '0;
                issue_ch_d  = issue_ch_q + 1'b1;
            end else begin
                issue_idx_d = issue_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            issue_ch_q  <= '0;
            issue_idx_q <= '0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            w_ch_q      <= '0;
            w_idx_q     <= '0;
            w_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            issue_ch_q  <= issue_ch_d;
            issue_idx_q <= issue_idx_d;
            w_valid_q   <= w_valid_d;
            w_data_q    <= w_data_d;
            w_ch_q      <= w_ch_d;
            w_idx_q     <= w_idx_d;
            w_last_q    <= w_last_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign w_if.w_valid = w_valid_q;
    assign w_if.w_data  = w_data_q;
    assign w_if.w_ch    = w_ch_q;
    assign w_if.w_idx   = w_idx_q;
    assign w_if.w_last  = w_last_q;
endmodule

// File: tb/tb_weights_load_ctrl.sv
module tb_weights_load_ctrl;
    localparam int K  = 25;
    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, done;
    logic [3:0]  rom_r_en;
    logic [4:0]  rom_raddr;
    logic [31:0] rom_dout;

    logic        start_s, busy_s, done_s;
    logic [0:0]  rom_r_en_s;
    logic [4:0]  rom_raddr_s;
    logic [7:0]  rom_dout_s;

    weights_load_ctrl_if #(.PARA_WIDTH(8), .CH_WIDTH(2), .ADDR_WIDTH(5)) wif ();
    weights_load_ctrl_if #(.PARA_WIDTH(8), .CH_WIDTH(1), .ADDR_WIDTH(5)) wif_s ();

    weights_load_ctrl #(.PARA_WIDTH(8), .KERNEL_SIZE(K), .ADDR_WIDTH(5), .NUM_CH(NC), .CH_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_r_en(rom_r_en), .rom_raddr(rom_raddr), .rom_dout(rom_dout), .w_if(wif.master));

    weights_load_ctrl #(.PARA_WIDTH(8), .KERNEL_SIZE(K), .ADDR_WIDTH(5), .NUM_CH(1), .CH_WIDTH(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
        .rom_r_en(rom_r_en_s), .rom_raddr(rom_raddr_s), .rom_dout(rom_dout_s), .w_if(wif_s.master));

    // ROM(c)[i] = c*32+i; a disabled ROM drives a junk pattern so reads
    // without the proper enable show up as bad data.
    always_comb begin
        rom_dout = '0;
        for (int c = 0; c < NC; c++)
            rom_dout[c*8 +: 8] = rom_r_en[c] ? 8'(c*32 + int'(rom_raddr)) : 8'hEE;
    end
    assign rom_dout_s = rom_r_en_s[0] ? 8'(rom_raddr_s) : 8'hEE;

    typedef struct { int ch; int idx; int data; } word_t;
    word_t q[$];
    word_t q_s[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, hs_cnt = 0, done_cnt = 0, done_s_cnt = 0;
    int first_valid = -1, last_done_cyc = -1;
    logic s_valid, s_done, s_busy;
    logic p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [7:0] p_data = '0;
    logic [1:0] p_ch = '0;
    logic [4:0] p_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_q();
        q.delete();
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < K; i++) q.push_back('{c, i, (c*32 + i) % 256});
    endtask

    // Sample at negedge, check, then advance one clock; inputs change #1 after posedge.
    task automatic step();
        word_t e;
        @(negedge clk);
        s_valid = wif.w_valid;
        s_done  = done;
        s_busy  = busy;
        if (rst) begin
            p_valid = 1'b0;
        end else begin
            chk("ren_onehot", 32'($onehot0(rom_r_en)), 1);
            if (rom_r_en != 0) chk("raddr_range", 32'(rom_raddr < 5'(K)), 1);
            if (p_valid && !p_ready) begin
                chk("stall_valid", wif.w_valid, 1);
                chk("stall_data", wif.w_data, p_data);
                chk("stall_ch", wif.w_ch, p_ch);
                chk("stall_idx", wif.w_idx, p_idx);
                chk("stall_last", wif.w_last, p_last);
            end
            if (wif.w_valid && !wif.w_ready) chk("stall_no_read", rom_r_en, 0);
            if (wif.w_valid && first_valid < 0) first_valid = cyc;
            if (wif.w_valid && wif.w_ready) begin
                chk("word_expected", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("w_ch", wif.w_ch, e.ch);
                    chk("w_idx", wif.w_idx, e.idx);
                    chk("w_data", wif.w_data, e.data);
                    chk("w_last", wif.w_last, 32'(e.idx == K-1));
                end
                hs_cnt++;
            end
            if (done) begin
                chk("done_all_words", q.size(), 0);
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (wif_s.w_valid && wif_s.w_ready) begin
                chk("s_word_expected", 32'(q_s.size() > 0), 1);
                if (q_s.size() > 0) begin
                    e = q_s.pop_front();
                    chk("s_w_ch", wif_s.w_ch, e.ch);
                    chk("s_w_idx", wif_s.w_idx, e.idx);
                    chk("s_w_data", wif_s.w_data, e.data);
                    chk("s_w_last", wif_s.w_last, 32'(e.idx == K-1));
                end
            end
            chk("s_ren_known", 32'($isunknown(rom_r_en_s)), 0);
            if (rom_r_en_s[0]) chk("s_raddr_range", 32'(rom_raddr_s < 5'(K)), 1);
            if (done_s) begin
                chk("s_done_all_words", q_s.size(), 0);
                done_s_cnt++;
            end
            p_valid = wif.w_valid;
            p_ready = wif.w_ready;
            p_data  = wif.w_data;
            p_ch    = wif.w_ch;
            p_idx   = wif.w_idx;
            p_last  = wif.w_last;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_done(input int ready_pct);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 1000) begin
            wif.w_ready = ($urandom_range(99) < ready_pct);
            step();
            n++;
        end
        chk("done_seen_once", done_cnt - d0, 1);
        chk("words_left", q.size(), 0);
        step();
        chk("done_one_cycle", s_done, 0);
        chk("busy_after_done", s_busy, 0);
    endtask

    initial begin
        int t0, n, tgt, d_before;
        rst = 1'b1; start = 1'b0; start_s = 1'b0;
        wif.w_ready = 1'b0; wif_s.w_ready = 1'b1;
        step(); step();
        rst = 1'b0;

        // Test 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_valid", wif.w_valid, 0);
            chk("idle_data", wif.w_data, 0);
            chk("idle_ch", wif.w_ch, 0);
            chk("idle_idx", wif.w_idx, 0);
            chk("idle_last", wif.w_last, 0);
            chk("idle_ren", rom_r_en, 0);
            chk("idle_raddr", rom_raddr, 0);
        end

        // Test 2 (+ test 6 on the single-channel instance): full rate load
        fill_q();
        q_s.delete();
        for (int i = 0; i < K; i++) q_s.push_back('{0, i, i});
        first_valid = -1;
        t0 = cyc;
        start = 1'b1; start_s = 1'b1; wif.w_ready = 1'b1;
        step();
        start = 1'b0; start_s = 1'b0;
        wait_done(100);
        chk("first_valid_lat", first_valid - t0, 2);
        chk("done_lat", last_done_cyc - t0, 102);
        chk("s_words_left", q_s.size(), 0);
        chk("s_done_count", done_s_cnt, 1);

        // Test 3: random 50% backpressure
        fill_q();
        start = 1'b1;
        wif.w_ready = $urandom_range(1);
        step();
        start = 1'b0;
        wait_done(50);

        // Test 4: start held through the load, then seen again in IDLE
        fill_q();
        t0 = cyc;
        start = 1'b1; wif.w_ready = 1'b1;
        step();
        wait_done(100);
        chk("held_done_lat", last_done_cyc - t0, 102);
        fill_q();
        step();
        chk("restart_busy", s_busy, 1);
        start = 1'b0;
        wait_done(100);

        // Test 5: reset after the 40th handshake
        fill_q();
        start = 1'b1;
        step();
        start = 1'b0;
        tgt = hs_cnt + 40;
        n = 0;
        while (hs_cnt < tgt && n < 2000) begin
            wif.w_ready = ($urandom_range(99) < 70);
            step();
            n++;
        end
        chk("reached_40_hs", hs_cnt, tgt);
        d_before = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_data", wif.w_data, 0);
        chk("rst_ch", wif.w_ch, 0);
        chk("rst_idx", wif.w_idx, 0);
        chk("rst_last", wif.w_last, 0);
        chk("rst_ren", rom_r_en, 0);
        chk("rst_raddr", rom_raddr, 0);
        for (int i = 0; i < 5; i++) step();
        chk("no_done_after_abort", done_cnt, d_before);
        fill_q();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
